u_mem_arb: RTL
==============

Name: u_mem_arb

Overview:
Single-port data/instruction memory arbiter shared between the fetch unit (IFU) and the execute-stage load/store port (LSU). It selects one request per cycle and drives the memory request channel. It tracks outstanding reads in an in-order owner FIFO and routes each read response back to its requester. LSU has fixed priority, with an IFU anti-starvation override. IFU reads still in flight can be discarded on a pipeline flush.

Parameters:
OUTS, 4, max outstanding reads (owner FIFO depth, power of 2, >=2)
STARVE_MAX, 3, consecutive IFU-lost cycles before the IFU gets forced priority (1..15)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
ifu_req  in  1  IFU read request; held with ifu_adr stable until ifu_gnt
ifu_adr  in  32  IFU word address
ifu_gnt  out  1  IFU request accepted this cycle
ifu_vld  out  1  IFU read data valid
ifu_rd  out  32  IFU read data
lsu_a  in  32  LSU byte address
lsu_we  in  4  LSU byte write enables; nonzero = write request
lsu_wd  in  32  LSU write data
lsu_re  in  4  LSU byte read enables; nonzero = read request
lsu_gnt  out  1  LSU request accepted this cycle
lsu_vld  out  1  LSU read data valid
lsu_rd  out  32  LSU read data
flush  in  1  discard all IFU reads in flight
mem_req  out  1  memory request valid
mem_gnt  in  1  memory accepts request this cycle
mem_a  out  32  memory address
mem_we  out  4  byte write enables (0 = read)
mem_re  out  4  byte read enables
mem_wd  out  32  write data
mem_rvld  in  1  read response valid (in order, at least 1 cycle after accept)
mem_rdata  in  32  read response data
busy  out  1  owner FIFO not empty
err  out  1  sticky: mem_rvld received with owner FIFO empty

Behaviour:
- Reset: owner FIFO empty (rd/wr ptr=0, count=0), starve_cnt=0, err=0. All outputs read 0 while in reset.
- LSU request: lsu_we!=0 | lsu_re!=0. If both are nonzero, the request is treated as a write and mem_re=0.
- Eligibility: writes are always eligible. Reads are eligible only if count<OUTS, or if count==OUTS and mem_rvld pops an entry in the same cycle.
- Selection (combinational): force = (starve_cnt==STARVE_MAX).
  - If force and the IFU request is eligible, select IFU.
  - Otherwise select the LSU if it is eligible, else the IFU if it is eligible.
- mem_req = a requester is selected. mem_a/mem_we/mem_re/mem_wd are muxed from the selected requester.
- IFU selected: mem_a=ifu_adr, mem_we=0, mem_re=4'b1111, mem_wd=0.
- No selection: mem_* outputs are 0.
- Grant: X_gnt = selected(X) & mem_gnt. Zero-cycle, combinational from mem_gnt.
- Push: on a granted read, push owner (0=IFU, 1=LSU) and a discard bit (0).
- Pop: on mem_rvld with count!=0, pop the head entry.
- Same-cycle push and pop: count unchanged. Count never exceeds OUTS and never underflows.
- Response routing (combinational, same cycle as mem_rvld):
  - ifu_vld = mem_rvld & head owner==IFU & ~head discard & ~flush.
  - lsu_vld = mem_rvld & head owner==LSU.
  - ifu_rd = lsu_rd = mem_rdata.
- Flush: sets the discard bit on every valid IFU entry present at the clock edge. A pop in the flush cycle of an IFU entry is suppressed. An IFU read granted in the flush cycle is not discarded. LSU entries are unaffected.
- Starvation counter starve_cnt (4b):
  - Increments, saturating at STARVE_MAX, in any cycle with ifu_req & ~ifu_gnt & lsu_gnt.
  - Clears to 0 on ifu_gnt.
  - Otherwise holds.
- err: set on mem_rvld & count==0. Cleared only by reset. The stray response is dropped, with no vld.
- Writes produce no response. Completion is lsu_gnt.
- mem_gnt=0 holds the selection logic but the state does not advance. The starve counter still counts only on an LSU grant.
- Reset mid-operation clears the FIFO. Responses arriving after reset set err.

Test Plan:
- IFU-only reads: ifu_req to 0x100, 0x104, 0x108 with mem_gnt=1 and 1-cycle rvld returning 0xA0,0xA1,0xA2 -> ifu_gnt every cycle, ifu_vld with data in order; busy drops after the last response.
- Contention: both request continuously, LSU reads at 0x2000 -> LSU granted 3 cycles, 4th cycle ifu_gnt=1 (force), starve_cnt returns to 0. Responses route to the correct port in order.
- FIFO full: mem_rvld held low, 4 IFU reads granted -> the 5th IFU read is not granted. An LSU write (lsu_we=4'hF, wd=0xDEADBEEF) is still granted with mem_we=4'hF.
- Flush: 2 IFU reads and 1 LSU read outstanding, flush pulse -> the IFU responses produce no ifu_vld, and the LSU response gives lsu_vld=1. An IFU read granted in the flush cycle returns ifu_vld=1.
- Stray response: mem_rvld=1 with FIFO empty -> err=1 and stays 1, no vld; rstn low clears it.
- Simultaneous push/pop at count==OUTS: an LSU read is granted in the same cycle a response pops -> count stays 4, no loss or duplication of owners.

Source files
------------

// File: rtl/u_mem_arb.sv
// Memory arbiter between fetch (IFU) and load/store (LSU) ports.
// Fixed LSU priority with IFU anti-starvation, in-order read owner tracking and IFU flush discard.
module u_mem_arb #(
  parameter int unsigned OUTS       = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ifu_req,
  input  logic [31:0] ifu_adr,
  output logic        ifu_gnt,
  output logic        ifu_vld,
  output logic [31:0] ifu_rd,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_gnt,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  input  logic        flush,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  output logic [3:0]  mem_we,
  output logic [3:0]  mem_re,
  output logic [31:0] mem_wd,
  input  logic        mem_rvld,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned PW = $clog2(OUTS);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = 4;

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [OUTS-1:0] owner, disc, disc_nxt;
  logic [SW-1:0]   starve_cnt;
  logic            err_q;

  logic lsu_wr, lsu_any, pop, rd_ok, ifu_elig, lsu_elig, force_ifu;
  logic sel_ifu, sel_lsu, gnt_ifu, gnt_lsu, push, head_own, head_disc;

  // Entry i is live when its distance from the head is below the occupancy.
  function automatic logic occupied(input int unsigned i);
    logic [PW-1:0] off;
    off = PW'(i) - rd_ptr;
    return {1'b0, off} < count;
  endfunction

  // Eligibility and selection
  always_comb begin
    lsu_wr    = |lsu_we;
    lsu_any   = lsu_wr | (|lsu_re);
    pop       = mem_rvld & (count != '0);
    rd_ok     = (count != CW'(OUTS)) | pop;
    ifu_elig  = ifu_req & rd_ok;
    lsu_elig  = lsu_any & (lsu_wr | rd_ok);
    force_ifu = (starve_cnt == SW'(STARVE_MAX));
    sel_ifu   = rstn & ifu_elig & (force_ifu | ~lsu_elig);
    sel_lsu   = rstn & lsu_elig & ~sel_ifu;
    gnt_ifu   = sel_ifu & mem_gnt;
    gnt_lsu   = sel_lsu & mem_gnt;
    push      = gnt_ifu | (gnt_lsu & ~lsu_wr);
    head_own  = owner[rd_ptr];
    head_disc = disc[rd_ptr];
  end

  // Request channel mux; a combined read+write LSU request goes out as a write.
  always_comb begin
    mem_a  = '0;
    mem_we = '0;
    mem_re = '0;
    mem_wd = '0;
    if (sel_ifu) begin
      mem_a  = ifu_adr;
      mem_re = 4'b1111;
    end else if (sel_lsu) begin
      mem_a  = lsu_a;
      mem_we = lsu_we;
      mem_re = lsu_wr ? 4'b0000 : lsu_re;
      mem_wd = lsu_wd;
    end
  end

  // Flush marks live IFU entries; a slot written this cycle starts clean.
  always_comb begin
    disc_nxt = disc;
    if (flush) begin
      for (int unsigned i = 0; i < OUTS; i++) begin
        if (occupied(i) && !owner[i]) disc_nxt[i] = 1'b1;
      end
    end
    if (push) disc_nxt[wr_ptr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      owner      <= '0;
      disc       <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) begin
        wr_ptr        <= wr_ptr + PW'(1);
        owner[wr_ptr] <= gnt_lsu;
      end
      count <= count + CW'(push) - CW'(pop);
      disc  <= disc_nxt;
      if (gnt_ifu) starve_cnt <= '0;
      else if (ifu_req && gnt_lsu && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
      if (mem_rvld && count == '0) err_q <= 1'b1;
    end
  end

  assign ifu_gnt = gnt_ifu;
  assign lsu_gnt = gnt_lsu;
  assign mem_req = sel_ifu | sel_lsu;
  assign ifu_vld = rstn & pop & ~head_own & ~head_disc & ~flush;
  assign lsu_vld = rstn & pop & head_own;
  assign ifu_rd  = rstn ? mem_rdata : 32'h0;
  assign lsu_rd  = rstn ? mem_rdata : 32'h0;
  assign busy    = (count != '0);
  assign err     = err_q;

endmodule
